// File: rtl/bram1be_arbiter.sv
// rtl/bram1be_arbiter.sv - two-requester arbiter/sequencer for a single-port byte-enable BRAM
// Define BRAM1BE_ARB_RR_EN for round-robin contention; default build is fixed priority (requester 0 wins).
module bram1be_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 4,
  parameter int PIPELINED  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic [WE_WIDTH-1:0]   REQ0_WE,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_DI,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic [WE_WIDTH-1:0]   REQ1_WE,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_DI,
  output logic                  RSP0_VALID,
  output logic [DATA_WIDTH-1:0] RSP0_DATA,
  output logic                  RSP1_VALID,
  output logic [DATA_WIDTH-1:0] RSP1_DATA,
  output logic                  BRAM_EN,
  output logic [WE_WIDTH-1:0]   BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int LAT = 1 + PIPELINED;

  logic            w_pri;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_rd;
  logic [LAT-1:0]  r_tag_v;
  logic [LAT-1:0]  r_tag_id;

`ifdef BRAM1BE_ARB_RR_EN
  logic r_pri;

  // Contended grant goes to r_pri; the loser gets priority next time.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pri <= 1'b0;
    end else if (REQ0_VALID && REQ1_VALID) begin
      r_pri <= ~r_pri;
    end
  end

  assign w_pri = r_pri;
`else
  assign w_pri = 1'b0;
`endif

  assign w_gnt0 = !RST && REQ0_VALID && (!REQ1_VALID || !w_pri);
  assign w_gnt1 = !RST && REQ1_VALID && (!REQ0_VALID || w_pri);

  assign REQ0_READY = w_gnt0;
  assign REQ1_READY = w_gnt1;

  assign BRAM_EN   = w_gnt0 || w_gnt1;
  assign BRAM_WE   = w_gnt1 ? REQ1_WE : (w_gnt0 ? REQ0_WE : '0);
  assign BRAM_ADDR = w_gnt1 ? REQ1_ADDR : REQ0_ADDR;
  assign BRAM_DI   = w_gnt1 ? REQ1_DI : REQ0_DI;

  assign w_rd = BRAM_EN && (BRAM_WE == '0);

  // Tag pipe mirrors the BRAM read latency so each DO lands on its issuer.
  generate
    if (LAT == 1) begin : g_lat1
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_tag_v  <= '0;
          r_tag_id <= '0;
        end else begin
          r_tag_v  <= w_rd;
          r_tag_id <= w_gnt1;
        end
      end
    end else begin : g_latn
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_tag_v  <= '0;
          r_tag_id <= '0;
        end else begin
          r_tag_v  <= {r_tag_v[LAT-2:0], w_rd};
          r_tag_id <= {r_tag_id[LAT-2:0], w_gnt1};
        end
      end
    end
  endgenerate

  assign RSP0_VALID = r_tag_v[LAT-1] && !r_tag_id[LAT-1];
  assign RSP1_VALID = r_tag_v[LAT-1] && r_tag_id[LAT-1];
  assign RSP0_DATA  = BRAM_DO;
  assign RSP1_DATA  = BRAM_DO;

endmodule

// File: tb/tb_bram1be_arbiter.sv
// tb/tb_bram1be_arbiter.sv - directed vector bench for bram1be_arbiter (PIPELINED=0 and =1 instances)
module tb_bram1be_arbiter;

`ifdef BRAM1BE_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic [1:0]  a_v, a_rdy, a_rv;
  logic [3:0]  a_we [2];
  logic [9:0]  a_ad [2];
  logic [31:0] a_di [2];
  logic [31:0] a_rd [2];
  logic        a_en;
  logic [3:0]  a_bwe;
  logic [9:0]  a_badr;
  logic [31:0] a_bdi, a_do;

  logic [1:0]  b_v, b_rdy, b_rv;
  logic [3:0]  b_we [2];
  logic [9:0]  b_ad [2];
  logic [31:0] b_di [2];
  logic [31:0] b_rd [2];
  logic        b_en;
  logic [3:0]  b_bwe;
  logic [9:0]  b_badr;
  logic [31:0] b_bdi, b_do, b_stage;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];

  bram1be_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WE_WIDTH(4), .PIPELINED(0)) u_dut_a (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(a_v[0]), .REQ0_READY(a_rdy[0]), .REQ0_WE(a_we[0]), .REQ0_ADDR(a_ad[0]), .REQ0_DI(a_di[0]),
    .REQ1_VALID(a_v[1]), .REQ1_READY(a_rdy[1]), .REQ1_WE(a_we[1]), .REQ1_ADDR(a_ad[1]), .REQ1_DI(a_di[1]),
    .RSP0_VALID(a_rv[0]), .RSP0_DATA(a_rd[0]), .RSP1_VALID(a_rv[1]), .RSP1_DATA(a_rd[1]),
    .BRAM_EN(a_en), .BRAM_WE(a_bwe), .BRAM_ADDR(a_badr), .BRAM_DI(a_bdi), .BRAM_DO(a_do)
  );

  bram1be_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WE_WIDTH(4), .PIPELINED(1)) u_dut_b (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(b_v[0]), .REQ0_READY(b_rdy[0]), .REQ0_WE(b_we[0]), .REQ0_ADDR(b_ad[0]), .REQ0_DI(b_di[0]),
    .REQ1_VALID(b_v[1]), .REQ1_READY(b_rdy[1]), .REQ1_WE(b_we[1]), .REQ1_ADDR(b_ad[1]), .REQ1_DI(b_di[1]),
    .RSP0_VALID(b_rv[0]), .RSP0_DATA(b_rd[0]), .RSP1_VALID(b_rv[1]), .RSP1_DATA(b_rd[1]),
    .BRAM_EN(b_en), .BRAM_WE(b_bwe), .BRAM_ADDR(b_badr), .BRAM_DI(b_bdi), .BRAM_DO(b_do)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // BRAM models: latency 1 (a) and latency 2 (b)
  always @(posedge clk) begin
    if (a_en) begin
      if (a_bwe == 4'h0) a_do <= mem_a[a_badr];
      else mem_a[a_badr] <= merge(mem_a[a_badr], a_bdi, a_bwe);
    end
  end

  always @(posedge clk) begin
    if (b_en) begin
      if (b_bwe == 4'h0) b_stage <= mem_b[b_badr];
      else mem_b[b_badr] <= merge(mem_b[b_badr], b_bdi, b_bwe);
    end
    b_do <= b_stage;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic v0; logic [3:0] we0; logic [9:0] a0; logic [31:0] d0;
    logic v1; logic [3:0] we1; logic [9:0] a1; logic [31:0] d1;
    logic r0; logic r1; logic en; logic [3:0] bwe; logic [9:0] badr;
    logic s0; logic s1; logic [31:0] sd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'hC0DE0000 | 32'(i);
      mem_b[i] = 32'hC0DE0000 | 32'(i);
    end
  end

  initial begin
    int c0, c1, k, cyc;
    logic pv, pid;
    logic [31:0] pdat;
    logic exp_ord [8];

    n_cmp = 0;
    n_err = 0;

    tbl[0]  = '{1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 10'd5, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 4'h0, 10'd5, 32'h0,        1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 10'd5, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 4'hF, 10'd7, 32'h11223344, 1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 10'd7, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 4'h5, 10'd7, 32'hAABBCCDD, 1'b0, 1'b1, 1'b1, 4'h5, 10'd7, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 4'h0, 10'd7, 32'h0,        1'b0, 1'b1, 1'b1, 4'h0, 10'd7, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 1'b0, 1'b1, 32'h11BB33DD};
    tbl[7]  = '{1'b1, 4'h0, 10'd5, 32'h0,        1'b1, 4'hF, 10'd9, 32'h12345678, 1'b1, 1'b0, 1'b1, 4'h0, 10'd5, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 4'hF, 10'd9, 32'h12345678, 1'b0, 1'b1, 1'b1, 4'hF, 10'd9, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 4'h0, 10'd9, 32'h0,        1'b0, 1'b1, 1'b1, 4'h0, 10'd9, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 4'h0, 10'd7, 32'h0,        1'b0, 4'h0, 10'd0, 32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 10'd7, 1'b0, 1'b1, 32'h12345678};
    tbl[11] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 1'b1, 1'b0, 32'h11BB33DD};
    tbl[12] = '{1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 4'h0, 10'd0, 32'h0,        1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 8; i++) exp_ord[i] = RR_BUILD ? i[0] : (i >= 4);

    // Reset with every requester asserting VALID
    for (int i = 0; i < 2; i++) begin
      a_we[i] = 4'h0; a_ad[i] = 10'd0; a_di[i] = 32'h0;
      b_we[i] = 4'h0; b_ad[i] = 10'd0; b_di[i] = 32'h0;
    end
    a_v = 2'b11;
    b_v = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_ready", {a_rdy, b_rdy}, 0);
    chk("rst_en_we", {a_en, b_en, a_bwe, b_bwe}, 0);
    chk("rst_rsp", {a_rv, b_rv}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_v = 2'b00;
    b_v = 2'b00;

    // Table vectors on the latency-1 instance
    for (int i = 0; i < 13; i++) begin
      a_v[0] = tbl[i].v0; a_we[0] = tbl[i].we0; a_ad[0] = tbl[i].a0; a_di[0] = tbl[i].d0;
      a_v[1] = tbl[i].v1; a_we[1] = tbl[i].we1; a_ad[1] = tbl[i].a1; a_di[1] = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), a_rdy, {tbl[i].r1, tbl[i].r0});
      chk($sformatf("vec%0d_en", i), a_en, tbl[i].en);
      chk($sformatf("vec%0d_we", i), a_bwe, tbl[i].bwe);
      if (tbl[i].en) begin
        chk($sformatf("vec%0d_addr", i), a_badr, tbl[i].badr);
        chk($sformatf("vec%0d_di", i), a_bdi, tbl[i].r1 ? tbl[i].d1 : tbl[i].d0);
      end
      chk($sformatf("vec%0d_rsp_v", i), a_rv, {tbl[i].s1, tbl[i].s0});
      if (tbl[i].s0) chk($sformatf("vec%0d_rsp0_d", i), a_rd[0], tbl[i].sd);
      if (tbl[i].s1) chk($sformatf("vec%0d_rsp1_d", i), a_rd[1], tbl[i].sd);
      @(posedge clk); #1;
    end

    // Idle: nothing may touch the BRAM
    a_v = 2'b00;
    b_v = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_en_we", {a_en, b_en, a_bwe, b_bwe}, 0);
      @(posedge clk); #1;
    end

    // Latency-2 back-to-back reads of addresses 0,1,2
    for (int c = 0; c < 6; c++) begin
      b_v[0] = (c < 3);
      b_we[0] = 4'h0;
      b_ad[0] = 10'(c);
      @(negedge clk);
      chk("p1_ready", b_rdy[0], (c < 3));
      chk("p1_rsp0_v", b_rv[0], (c >= 2 && c <= 4));
      chk("p1_rsp1_v", b_rv[1], 1'b0);
      if (c >= 2 && c <= 4) chk("p1_rsp0_d", b_rd[0], 32'hC0DE0000 | 32'(c - 2));
      @(posedge clk); #1;
    end
    b_v = 2'b00;

    // Reset one cycle after a latency-2 read is accepted
    b_v[0] = 1'b1;
    b_ad[0] = 10'd1;
    @(negedge clk);
    chk("mid_ready", b_rdy[0], 1'b1);
    @(posedge clk); #1;
    b_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    a_v = 2'b11;
    b_v = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_ready", {a_rdy, b_rdy}, 0);
      chk("mid_rst_en_we", {a_en, b_en, a_bwe, b_bwe}, 0);
      chk("mid_rst_rsp", {a_rv, b_rv}, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    a_v = 2'b00;
    b_v = 2'b00;

    // Contention: four reads each, starting right after reset release
    c0 = 0; c1 = 0; k = 0; cyc = 0;
    pv = 1'b0; pid = 1'b0; pdat = 32'h0;
    while ((c0 < 4 || c1 < 4) && cyc < 20) begin
      a_v[0] = (c0 < 4); a_we[0] = 4'h0; a_ad[0] = 10'(20 + c0);
      a_v[1] = (c1 < 4); a_we[1] = 4'h0; a_ad[1] = 10'(30 + c1);
      @(negedge clk);
      chk("cont_rsp0_v", a_rv[0], pv && !pid);
      chk("cont_rsp1_v", a_rv[1], pv && pid);
      if (pv) chk("cont_rsp_d", pid ? a_rd[1] : a_rd[0], pdat);
      chk("cont_b_quiet", b_rv, 0);
      chk("cont_onehot", {1'b0, a_rdy[0]} + {1'b0, a_rdy[1]}, 1);
      if (a_rdy != 2'b00) begin
        pid = a_rdy[1];
        if (k < 8) chk($sformatf("cont_order%0d", k), pid, exp_ord[k]);
        pdat = 32'hC0DE0000 | (pid ? 32'(30 + c1) : 32'(20 + c0));
        pv = 1'b1;
        if (pid) c1++; else c0++;
        k++;
      end else begin
        pv = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_v = 2'b00;
    if (c0 < 4 || c1 < 4) begin
      n_cmp++;
      n_err++;
      $display("FAIL cont_timeout: grants r0=%0d r1=%0d required 4 each", c0, c1);
    end
    @(negedge clk);
    chk("cont_last_rsp0_v", a_rv[0], pv && !pid);
    chk("cont_last_rsp1_v", a_rv[1], pv && pid);
    if (pv) chk("cont_last_rsp_d", pid ? a_rd[1] : a_rd[0], pdat);
    chk("cont_grants", k, 8);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cont_drain", a_rv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram1be_arbiter.md
# bram1be_arbiter

Two-requester arbiter and sequencer for a single-ported byte-enable BRAM (the `BRAM1BELoad`-style primitive). It grants one request per cycle to the BRAM, drives its `EN`/`WE`/`ADDR`/`DI` pins, and tracks in-flight reads through the BRAM's 1- or 2-cycle read latency. Each read's `DO` is returned to the requester that issued it. It sits between two bus-side clients, for example a host config path and a datapath engine, and one shared memory instance.

## Interface

Parameters:
- `ADDR_WIDTH`, default 10: BRAM address width.
- `DATA_WIDTH`, default 32: BRAM data width.
- `WE_WIDTH`, default 4: byte-enable width; one bit per `DATA_WIDTH/WE_WIDTH` chunk.
- `PIPELINED`, default 0: must match the BRAM setting; read latency is `1+PIPELINED` cycles.

Ports:
- `CLK`  in  1  sole clock; all state changes on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `REQ0_VALID`, `REQ1_VALID`  in  1  request present.
- `REQ0_READY`, `REQ1_READY`  out  1  request granted this cycle (combinational).
- `REQ0_WE`, `REQ1_WE`  in  WE_WIDTH  byte enables; all-zero means read.
- `REQ0_ADDR`, `REQ1_ADDR`  in  ADDR_WIDTH  address.
- `REQ0_DI`, `REQ1_DI`  in  DATA_WIDTH  write data.
- `RSP0_VALID`, `RSP1_VALID`  out  1  read data valid, one-cycle pulse; no backpressure.
- `RSP0_DATA`, `RSP1_DATA`  out  DATA_WIDTH  read data, both driven from `BRAM_DO`.
- `BRAM_EN`  out  1  BRAM enable.
- `BRAM_WE`  out  WE_WIDTH  BRAM byte enables.
- `BRAM_ADDR`  out  ADDR_WIDTH  BRAM address.
- `BRAM_DI`  out  DATA_WIDTH  BRAM write data.
- `BRAM_DO`  in  DATA_WIDTH  BRAM read data.

## Operation

- Requests transfer on the rising edge where `VALID && READY`. At most one `READY` is high per cycle.
- Grant selection:
  - Exactly one `VALID` high: that requester is granted.
  - Both high: the requester selected by priority pointer `pri` is granted.
- `pri` is a 1-bit register, reset to 0. On a contended grant it updates to the requester that lost, giving round-robin between the two. An uncontended grant leaves `pri` unchanged.
- Granted request goes straight to the BRAM in the same cycle:
  - `BRAM_EN=1`
  - `BRAM_WE/ADDR/DI` = granted requester's fields.
- No grant: `BRAM_EN=0`, `BRAM_WE=0`. `ADDR`/`DI` are don't-care, driven from requester 0.
- Reads (`WE==0`) push tag `{valid=1, id}` into a shift register of depth `1+PIPELINED`. Writes push `valid=0`: writes produce no response.
- Tag at the shift-register output with `valid=1` asserts `RSP<id>_VALID`. `RSP*_DATA = BRAM_DO`, unconditionally.
- A requester may issue back-to-back reads every cycle. Responses return in issue order.
- Mixed read/write order is preserved by the single port. A read after a write to the same address returns the new data.
- Reset (async):
  - `pri=0`; tag pipe cleared.
  - While `RST=1`: `REQ*_READY=0`, `BRAM_EN=0`, `BRAM_WE=0`, `RSP*_VALID=0`.
  - Reads in flight when reset asserts are dropped; no response is ever issued for them.

## Timing

- Read accepted at edge T:
  - `PIPELINED=0`: `RSPx_VALID` high during cycle T+1.
  - `PIPELINED=1`: `RSPx_VALID` high during cycle T+2.
- Throughput is one request per cycle aggregate; sustained contention alternates grants R0,R1,R0,…
- `READY` depends combinationally on both `VALID`s and `pri`. Requesters must not make `VALID` depend on `READY`.
- Reset values of all outputs are 0. `RSP*_DATA` follows `BRAM_DO`; its value during reset is not specified.
- First grant is possible in the first cycle after `RST` deasserts.

## Configuration

- `BRAM1BE_ARB_RR_EN`
  - Defined: round-robin as described above.
  - Undefined: fixed priority. Requester 0 always wins contention; the `pri` register is not instantiated.
  - All other behaviour is identical in both builds.

## Test plan

- Single write then read, `PIPELINED=0`, R0:
  - Stimulus: write `ADDR=5 WE=4'hF DI=32'hDEADBEEF`, then read `ADDR=5`.
  - Required: no response to the write; `RSP0_VALID` one cycle after the read accept, `RSP0_DATA=32'hDEADBEEF`.
- Byte-enable merge:
  - Stimulus: `ADDR=7` holds `32'h11223344`; R1 writes `WE=4'b0101 DI=32'hAABBCCDD`, then reads.
  - Required: `RSP1_DATA=32'h11BB33DD`.
- Contention, RR build:
  - Stimulus: both requesters hold `VALID` for 4 reads each.
  - Required: grant order R0,R1,R0,R1,…; 8 responses, each on the correct `RSPx` at T+1.
  - Same stimulus, fixed-priority build: 4×R0 then 4×R1.
- `PIPELINED=1` back-to-back:
  - Stimulus: R0 reads `ADDR` 0,1,2 on consecutive cycles.
  - Required: `RSP0_VALID` high 3 consecutive cycles starting at T+2, data in address order.
- Reset mid-flight:
  - Stimulus: assert `RST` one cycle after a read accept with `PIPELINED=1`.
  - Required: no `RSP*_VALID` ever appears for that read; `READY`/`BRAM_EN` stay 0 while `RST=1`; after release, the next contention grants R0 first.
- Idle:
  - Stimulus: no `VALID` for 10 cycles.
  - Required: `BRAM_EN=0` and `BRAM_WE=0` throughout.
